// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared result type and one-hot flag constants for the comparator
package cmp_pkg;

  // Packed {L,E,G}; all-zero is reserved for "no result captured yet".
  typedef logic [2:0] cmp_res_t;

  localparam cmp_res_t CMP_LT   = 3'b100;
  localparam cmp_res_t CMP_EQ   = 3'b010;
  localparam cmp_res_t CMP_GT   = 3'b001;
  localparam cmp_res_t CMP_NONE = 3'b000;

endpackage

// File: rtl/cmp_core.sv
// rtl/cmp_core.sv - combinational magnitude compare producing one-hot {L,E,G}
module cmp_core
  import cmp_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int SIGNED = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output cmp_res_t         res
);

  logic lt;
  logic eq;

  // Signedness only changes the ordering; equality is identical either way.
  generate
    if (SIGNED != 0) begin : g_signed
      assign lt = $signed(a) < $signed(b);
    end else begin : g_unsigned
      assign lt = a < b;
    end
  endgenerate

  assign eq = (a == b);

  // Anything neither equal nor less must be greater, so the result is always one-hot.
  always_comb begin
    res = CMP_GT;
    if (eq) begin
      res = CMP_EQ;
    end else if (lt) begin
      res = CMP_LT;
    end
  end

endmodule

// File: rtl/bit_comparator.sv
// rtl/bit_comparator.sv - registered comparator with one-hot L/E/G flags and valid
module bit_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             L,
  output logic             E,
  output logic             G,
  output logic             valid
);

  cmp_res_t cmp_res;
  cmp_res_t flags_q;
  logic     valid_q;

  cmp_core #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_core (
    .a   (A),
    .b   (B),
    .res (cmp_res)
  );

  // Capture the compare result on enabled edges; hold otherwise; clear at once on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= CMP_NONE;
      valid_q <= 1'b0;
    end else if (en) begin
      flags_q <= cmp_res;
      valid_q <= 1'b1;
    end
  end

  assign {L, E, G} = flags_q;
  assign valid     = valid_q;

endmodule

// File: tb/tb_bit_comparator.sv
// tb/tb_bit_comparator.sv - randomized self-checking bench for bit_comparator
module tb_bit_comparator;

  localparam int N = 4;
  localparam int W_TAB [N] = '{1, 1, 8, 8};
  localparam int S_TAB [N] = '{0, 1, 0, 1};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] a_in;
  logic [7:0] b_in;

  logic       l0, e0, g0, v0;
  logic       l1, e1, g1, v1;
  logic       l2, e2, g2, v2;
  logic       l3, e3, g3, v3;
  logic [2:0] got_f [N];
  logic       got_v [N];

  logic [2:0] exp_f [N];
  logic       exp_v;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bit_comparator #(.WIDTH(1), .SIGNED(0)) u_u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .A(a_in[0]), .B(b_in[0]),
    .L(l0), .E(e0), .G(g0), .valid(v0));
  bit_comparator #(.WIDTH(1), .SIGNED(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .en(en), .A(a_in[0]), .B(b_in[0]),
    .L(l1), .E(e1), .G(g1), .valid(v1));
  bit_comparator #(.WIDTH(8), .SIGNED(0)) u_u8 (
    .clk(clk), .rst_n(rst_n), .en(en), .A(a_in), .B(b_in),
    .L(l2), .E(e2), .G(g2), .valid(v2));
  bit_comparator #(.WIDTH(8), .SIGNED(1)) u_s8 (
    .clk(clk), .rst_n(rst_n), .en(en), .A(a_in), .B(b_in),
    .L(l3), .E(e3), .G(g3), .valid(v3));

  assign got_f[0] = {l0, e0, g0};
  assign got_f[1] = {l1, e1, g1};
  assign got_f[2] = {l2, e2, g2};
  assign got_f[3] = {l3, e3, g3};
  assign got_v[0] = v0;
  assign got_v[1] = v1;
  assign got_v[2] = v2;
  assign got_v[3] = v3;

  // Interpret the low w bits of raw as an integer, two's complement when s is set.
  function automatic longint to_num(input logic [7:0] raw, input int w, input int s);
    longint v;
    v = longint'(raw) & ((longint'(1) << w) - 1);
    if (s != 0 && v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
    return v;
  endfunction

  function automatic logic [2:0] ref_cmp(input longint x, input longint y);
    if (x < y) return 3'b100;
    if (x == y) return 3'b010;
    return 3'b001;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s_i%0d_flags", tag, i), 64'(got_f[i]), 64'(exp_f[i]));
      check($sformatf("%s_i%0d_valid", tag, i), 64'(got_v[i]), 64'(exp_v));
      check($sformatf("%s_i%0d_onehot", tag, i), 64'($onehot(got_f[i])), 64'(exp_v));
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) exp_f[i] = 3'b000;
    exp_v = 1'b0;
  endtask

  // Drive between edges, then update the model for the edge and check just after it.
  task automatic step(input string tag, input logic e, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    en   = e;
    a_in = a;
    b_in = b;
    @(posedge clk);
    if (e) begin
      for (int i = 0; i < N; i++)
        exp_f[i] = ref_cmp(to_num(a, W_TAB[i], S_TAB[i]), to_num(b, W_TAB[i], S_TAB[i]));
      exp_v = 1'b1;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    model_clear();
    rst_n = 1'b1;
    en    = 1'b1;
    a_in  = 8'h01;
    b_in  = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    check_all("reset_async");
    @(posedge clk);
    #1;
    check_all("reset_held");
    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=1 unsigned sweep plus spot checks against fixed answers.
    step("sw00", 1'b1, 8'h00, 8'h00);
    check("sw00_u1_E", 64'(e0), 64'd1);
    step("sw10", 1'b1, 8'h01, 8'h00);
    check("sw10_u1_G", 64'(g0), 64'd1);
    check("sw10_s1_L", 64'(l1), 64'd1);
    step("sw11", 1'b1, 8'h01, 8'h01);
    check("sw11_u1_E", 64'(e0), 64'd1);
    step("sw01", 1'b1, 8'h00, 8'h01);
    check("sw01_u1_L", 64'(l0), 64'd1);
    check("sw01_s1_G", 64'(g1), 64'd1);

    // Hold with en low while inputs move.
    step("hold_cap", 1'b1, 8'h01, 8'h00);
    for (int k = 0; k < 3; k++) begin
      step("hold", 1'b0, 8'h00, 8'h01);
      check("hold_u1_G", 64'(g0), 64'd1);
    end

    // Reset pulsed between edges clears immediately; first enabled edge reloads.
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    check_all("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    step("postrst_idle", 1'b0, 8'h00, 8'h01);
    step("postrst_eq", 1'b1, 8'hA5, 8'hA5);
    check("postrst_u1_E", 64'(e0), 64'd1);
    check("postrst_s8_E", 64'(e3), 64'd1);

    // 8-bit boundary vectors.
    step("ff00", 1'b1, 8'hFF, 8'h00);
    check("ff00_u8_G", 64'(g2), 64'd1);
    check("ff00_s8_L", 64'(l3), 64'd1);
    step("7f80", 1'b1, 8'h7F, 8'h80);
    check("7f80_u8_L", 64'(l2), 64'd1);
    check("7f80_s8_G", 64'(g3), 64'd1);

    // Random traffic, biased toward equal operands and occasional idle cycles.
    for (int k = 0; k < 300; k++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic       re;
      ra = 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
      re = ($urandom_range(0, 3) != 0);
      step("rand", re, ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bit_comparator.md
Name: bit_comparator

Overview:
- Registered magnitude comparator of two operands A and B, default width 1 bit.
- Drives three one-hot flags: L (A<B), E (A==B), G (A>B).
- Used as a leaf compare element in datapath and control logic.
- Parameterizable to wider and signed operands; one pipeline register on the outputs.

Parameters:
- WIDTH, 1, operand width in bits; legal range 1..64.
- SIGNED, 0, 0 = unsigned compare; 1 = two's-complement compare.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- en  input  1  compare enable; when 1, the result is captured at the next rising edge.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- L  output  1  registered flag, A less than B.
- E  output  1  registered flag, A equal to B.
- G  output  1  registered flag, A greater than B.
- valid  output  1  high once at least one enabled compare has been captured since reset.

Behaviour:
- Reset (rst_n=0, asynchronous, effective immediately regardless of clk):
  - L=0, E=0, G=0, valid=0.
  - All-zero flags is the only legal non-one-hot state; it means "no result yet".
- Compare function (combinational, pre-register):
  - lt = A<B; eq = A==B; gt = A>B.
  - SIGNED=0: unsigned compare. WIDTH=1: 0<1.
  - SIGNED=1: MSB is the sign bit. WIDTH=1: value 1 means -1, so 1<0.
- Capture:
  - Rising clk with rst_n=1 and en=1: {L,E,G} <= {lt,eq,gt}; valid <= 1.
  - en=0: L, E, G and valid hold their previous values.
- Latency: one cycle from A/B/en sampled at edge N to flags visible after edge N.
- Invariant: after valid=1, exactly one of L, E, G is 1 on every cycle until the next reset.
- Inputs changing between edges: no effect on the outputs, because the outputs are registered only.
- Reset asserted mid-operation: flags and valid clear immediately. The first enabled edge after rst_n deasserts reloads them.
- Reset deassertion is synchronized externally; the block itself has no synchronizer.
- X on A/B with en=1 is a bench error; the RTL does not need to handle it.

Decomposition:
- Shared package cmp_pkg:
  - typedef cmp_res_t, a 3-bit packed {L,E,G}.
  - Constants CMP_LT=3'b100, CMP_EQ=3'b010, CMP_GT=3'b001, CMP_NONE=3'b000.
- One sub-module is natural: cmp_core.
  - Purely combinational; parameterized by WIDTH/SIGNED; returns cmp_res_t.
  - bit_comparator instantiates cmp_core and adds the register stage plus valid.

Test Plan:
- Reset: rst_n=0 with A=1, B=0, en=1 -> L=E=G=0, valid=0, immediately and without a clk edge.
- WIDTH=1 unsigned sweep, en=1, 10 ns per step, flags checked one cycle after each step:
  - A=0,B=0 -> E=1.
  - A=1,B=0 -> G=1.
  - A=1,B=1 -> E=1.
  - A=0,B=1 -> L=1.
  - valid=1 throughout the sweep.
- Hold: capture A=1,B=0 (G=1), then en=0 with A=0,B=1 for 3 cycles -> flags remain G=1.
- Mid-operation reset: pulse rst_n low between edges while G=1 -> flags clear at once. First enabled edge after release with A=B -> E=1.
- WIDTH=1, SIGNED=1:
  - A=1,B=0 -> L=1.
  - A=0,B=1 -> G=1.
- WIDTH=8 unsigned:
  - A=8'hFF,B=8'h00 -> G=1.
  - A=8'h7F,B=8'h80 -> L=1.
- WIDTH=8 signed:
  - A=8'h7F,B=8'h80 -> G=1.
  - A=B=8'hA5 -> E=1.
